sseg_disp_ctrl: RTL
===================

Name: sseg_disp_ctrl

Overview:
- Display controller for the DE0-CV HEX bank, NUM_DIGITS seven-segment digits.
- Holds the display value, per-digit decimal points, blink mask and blanking configuration.
- Every clock it computes per-digit data/en/dp triplets, one sseg_dec instance per digit.
- Host logic updates the display by bulk load or by shifting in one digit.

Parameters:
- NUM_DIGITS, 6, number of driven digits (1..8).
- BLINK_DIV, 12500000, clk cycles per blink half-period (50 MHz gives 2 Hz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ld_valid  in  1  bulk-load strobe
- ld_data  in  4*NUM_DIGITS  digit values, digit 0 in bits [3:0]
- ld_dp  in  NUM_DIGITS  decimal points for bulk load
- sh_valid  in  1  shift-in strobe
- sh_data  in  4  new digit 0 value
- sh_dp  in  1  new digit 0 decimal point
- cfg_we  in  1  configuration write strobe
- cfg_on  in  1  global display enable
- cfg_lz  in  1  leading-zero blanking enable
- cfg_blink  in  NUM_DIGITS  per-digit blink mask
- dig_data  out  4*NUM_DIGITS  per-digit nibble to sseg_dec data
- dig_en  out  NUM_DIGITS  per-digit enable to sseg_dec en
- dig_dp  out  NUM_DIGITS  per-digit dp to sseg_dec dp
- blink_phase  out  1  current blink phase; 1 = blinking digits dark

Behaviour:
- Reset values:
  - value registers 0, dp registers 0, cfg_blink 0, cfg_lz 0, cfg_on 1.
  - Blink counter 0, blink_phase 0.
  - Outputs dig_data 0, dig_en 0, dig_dp 0.
- Outputs are registered. A command sampled at edge k is visible on the outputs after edge k+1.
  - First edge after rst deasserts: digit 0 shows "0" with dig_en all 1, because blanking is off.
- Bulk load, ld_valid=1: value <= ld_data, dp <= ld_dp.
- Shift, sh_valid=1 and ld_valid=0:
  - value <= {value[4*NUM_DIGITS-5:0], sh_data}; dp <= {dp[NUM_DIGITS-2:0], sh_dp}.
  - The top digit is discarded.
- Simultaneous ld_valid and sh_valid: load wins, shift is dropped.
- cfg_we: cfg_on, cfg_lz and cfg_blink are updated. This is independent of load/shift, and both may occur in the same cycle.
- Blink timer:
  - Counter runs 0..BLINK_DIV-1. At BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
  - It runs continuously and is not reset by commands.
  - BLINK_DIV=1 toggles the phase every cycle.
- Leading-zero blanking, evaluated on the next-state value, when cfg_lz=1:
  - Scanning from digit NUM_DIGITS-1 downward, digit i is blanked while value[i]==0 and dp[i]==0.
  - Blanking stops at the first nonzero digit or the first digit with dp set.
  - Digit 0 is never blanked, so 000000 displays as "0".
- Per-digit enable: dig_en[i] = cfg_on & ~blank_lz[i] & ~(cfg_blink[i] & blink_phase).
- Pass-through: dig_data and dig_dp always carry the stored values. Blanking acts only through dig_en, and sseg_dec forces the segments off.
- cfg_on=0: all dig_en are 0. Stored value, dp and blink timer keep running.
- rst asserted mid-operation: all registers and outputs take reset values on that edge. Commands in the same cycle are ignored.

Decomposition:
- Package sseg_pkg holds:
  - the default digit count constant;
  - the BLINK_DIV default for 50 MHz;
  - a helper function for leading-zero mask generation.
- Sub-module sseg_blink_timer (parameter BLINK_DIV; ports clk, rst, phase) is the only natural split.
- sseg_dec instances are placed at board top level, not inside this block.

Test Plan:
- Reset, then idle 2 cycles -> dig_data=0, dig_dp=0, dig_en=6'b111111, blink_phase=0.
- cfg_we with cfg_lz=1, then ld_data=24'h000305, ld_dp=0 -> one cycle later dig_en=6'b000111, dig_data=24'h000305.
- Lz on, ld_data=24'h000000 with ld_dp=6'b000100 -> dig_en=6'b000111; with ld_dp=0 -> dig_en=6'b000001.
- BLINK_DIV=4, cfg_blink=6'b000011 -> blink_phase toggles every 4 cycles; dig_en[1:0] low exactly while phase=1, other digits constant.
- After load of 24'h123456: sh_valid with sh_data=4'h7, sh_dp=1 -> dig_data=24'h234567, dig_dp[0]=1. Same-cycle ld_valid(24'hABCDEF) plus sh_valid -> 24'hABCDEF.
- cfg_on=0 -> dig_en=0 next cycle; data retained. rst pulsed during a load cycle -> value 0, load ignored.

Source files
------------

// File: rtl/sseg_disp_ctrl_pkg.sv
// Shared constants and helpers for the seven-segment display controller.
package sseg_pkg;

   localparam int DEFAULT_NUM_DIGITS = 6;
   localparam int DEFAULT_BLINK_DIV  = 12500000;
   localparam int MAX_DIGITS         = 8;

   // Returns a per-digit mask of leading zeros to be blanked. The scan walks
   // from the top digit downward and stops at the first nonzero digit or the
   // first digit carrying a decimal point. Digit 0 is never blanked so an
   // all-zero value still shows a single "0".
   function automatic logic [MAX_DIGITS-1:0] lzMask(
      input logic [4*MAX_DIGITS-1:0] value,
      input logic [MAX_DIGITS-1:0]   dp,
      input int                      numDigits
   );
      logic [MAX_DIGITS-1:0] mask;
      logic                  blanking;
      mask     = '0;
      blanking = 1'b1;
      for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
         if (i < numDigits) begin
            if (blanking && (value[4*i +: 4] == 4'h0) && !dp[i]) begin
               mask[i] = 1'b1;
            end else begin
               blanking = 1'b0;
            end
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/sseg_disp_ctrl_blink_timer.sv
// Free-running blink timer: toggles the phase every BLINK_DIV clocks.
module sseg_blink_timer
   import sseg_pkg::*;
#(
   parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic phase
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] r_count;
   logic          r_phase;

   // Count 0..BLINK_DIV-1, wrapping and toggling the phase on the last count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_phase <= 1'b0;
      end else if (r_count == CW'(BLINK_DIV - 1)) begin
         r_count <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign phase = r_phase;

endmodule

// File: rtl/sseg_disp_ctrl.sv
// Display controller for a bank of seven-segment digits: holds the value,
// decimal points and display configuration and produces per-digit
// data/en/dp for the downstream decoders.
module sseg_disp_ctrl
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
   parameter int BLINK_DIV  = DEFAULT_BLINK_DIV
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ld_valid,
   input  logic [4*NUM_DIGITS-1:0] ld_data,
   input  logic [NUM_DIGITS-1:0]   ld_dp,
   input  logic                    sh_valid,
   input  logic [3:0]              sh_data,
   input  logic                    sh_dp,
   input  logic                    cfg_we,
   input  logic                    cfg_on,
   input  logic                    cfg_lz,
   input  logic [NUM_DIGITS-1:0]   cfg_blink,
   output logic [4*NUM_DIGITS-1:0] dig_data,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic [NUM_DIGITS-1:0]   dig_dp,
   output logic                    blink_phase
);

   logic [4*NUM_DIGITS-1:0] r_value;
   logic [NUM_DIGITS-1:0]   r_dp;
   logic                    r_on;
   logic                    r_lz;
   logic [NUM_DIGITS-1:0]   r_blink;
   logic [NUM_DIGITS-1:0]   r_enBase;

   logic [4*NUM_DIGITS-1:0] w_valueNext;
   logic [NUM_DIGITS-1:0]   w_dpNext;
   logic                    w_onNext;
   logic                    w_lzNext;
   logic [NUM_DIGITS-1:0]   w_blinkNext;
   logic [NUM_DIGITS-1:0]   w_enBaseNext;
   logic [4*NUM_DIGITS+3:0] w_shiftValue;
   logic [NUM_DIGITS:0]     w_shiftDp;
   logic [MAX_DIGITS-1:0]   w_lzMaskFull;
   logic [NUM_DIGITS-1:0]   w_blankLz;
   logic                    w_phase;

   sseg_blink_timer #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blinkTimer (
      .clk   (clk),
      .rst   (rst),
      .phase (w_phase)
   );

   // The extra width lets a one-digit build shift without an empty slice;
   // the top digit falls off the end when the result is truncated.
   assign w_shiftValue = {r_value, sh_data};
   assign w_shiftDp    = {r_dp, sh_dp};

   assign w_lzMaskFull = lzMask(32'(w_valueNext), 8'(w_dpNext), NUM_DIGITS);

   // Next-state selection: load beats shift, config writes are independent,
   // and blanking is judged on the values about to be stored.
   always_comb begin
      w_valueNext  = r_value;
      w_dpNext     = r_dp;
      w_onNext     = r_on;
      w_lzNext     = r_lz;
      w_blinkNext  = r_blink;
      w_blankLz    = '0;
      w_enBaseNext = '0;
      if (ld_valid) begin
         w_valueNext = ld_data;
         w_dpNext    = ld_dp;
      end else if (sh_valid) begin
         w_valueNext = w_shiftValue[4*NUM_DIGITS-1:0];
         w_dpNext    = w_shiftDp[NUM_DIGITS-1:0];
      end
      if (cfg_we) begin
         w_onNext    = cfg_on;
         w_lzNext    = cfg_lz;
         w_blinkNext = cfg_blink;
      end
      if (w_lzNext) begin
         w_blankLz = w_lzMaskFull[NUM_DIGITS-1:0];
      end
      w_enBaseNext = {NUM_DIGITS{w_onNext}} & ~w_blankLz;
   end

   // State and output registers; reset overrides any same-cycle command
   always_ff @(posedge clk) begin
      if (rst) begin
         r_value  <= '0;
         r_dp     <= '0;
         r_on     <= 1'b1;
         r_lz     <= 1'b0;
         r_blink  <= '0;
         r_enBase <= '0;
      end else begin
         r_value  <= w_valueNext;
         r_dp     <= w_dpNext;
         r_on     <= w_onNext;
         r_lz     <= w_lzNext;
         r_blink  <= w_blinkNext;
         r_enBase <= w_enBaseNext;
      end
   end

   // Blink gating combines only flops, so it lines up exactly with blink_phase
   assign dig_data    = r_value;
   assign dig_dp      = r_dp;
   assign dig_en      = r_enBase & ~(r_blink & {NUM_DIGITS{w_phase}});
   assign blink_phase = w_phase;

endmodule
